count_uart_reporter: RTL and testbench

- Downstream consumer of the S-Machine top-level count[7:0] output.
- Detects changes on count and reports each new value over a UART 8N1 serial line as three ASCII bytes: two upper-case hex digits, then LF (0x0A).
- Buffers one pending value; a newer value overwrites an unsent one ("latest wins"), and every overwrite is counted.
- Lets the board report CPU progress to a host terminal without a debugger.

---
 rtl/count_uart_pkg.sv | 27 ++
 rtl/count_uart_reporter_uart_tx_byte.sv | 92 +++++++++
 rtl/count_uart_reporter.sv | 117 +++++++++++
 tb/tb_count_uart_reporter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_uart_pkg.sv
// Shared types and constants for the count UART reporter.
package count_uart_pkg;

  // Serializer line states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Line feed that terminates every report
  localparam logic [7:0] LF_CHAR = 8'h0A;

  // Bytes per report: high digit, low digit, LF
  localparam int FRAME_BYTES = 3;

  // Upper-case ASCII hex digit for a nibble
  function automatic logic [7:0] hex_to_ascii(input logic [3:0] nibble);
    if (nibble < 4'd10) begin
      return 8'h30 + {4'h0, nibble};
    end else begin
      return 8'h37 + {4'h0, nibble};
    end
  endfunction

endpackage

// File: rtl/count_uart_reporter_uart_tx_byte.sv
// 8N1 byte serializer with a valid/ready input handshake.
// in_ready is also high on the last STOP cycle so the next byte of a
// frame follows the stop bit with no idle gap.
module uart_tx_byte
  import count_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       done,
  output logic       tx
);

  localparam logic [15:0] TICK_LAST = 16'(CLKS_PER_BIT - 1);

  uart_state_e state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        bit_tick;
  logic        accept;

  assign bit_tick = (timer_q == TICK_LAST);
  assign accept   = in_valid && in_ready;

  // State register and datapath flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid) state_d = ST_START;
      ST_START: if (bit_tick) state_d = ST_DATA;
      ST_DATA:  if (bit_tick && (bit_idx_q == 3'd7)) state_d = ST_STOP;
      ST_STOP:  if (bit_tick) state_d = in_valid ? ST_START : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Bit timer, bit index and shift register; timer restarts on every state entry
  always_comb begin
    timer_d   = timer_q + 16'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    if ((state_q == ST_IDLE) || bit_tick || (state_d != state_q)) begin
      timer_d = '0;
    end
    if ((state_q == ST_DATA) && bit_tick) begin
      bit_idx_d = bit_idx_q + 3'd1;
      shift_d   = {1'b0, shift_q[7:1]};
    end
    if (accept) begin
      bit_idx_d = '0;
      shift_d   = in_data;
    end
  end

  // Outputs decoded from the current state
  always_comb begin
    tx       = 1'b1;
    in_ready = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_START: tx = 1'b0;
      ST_DATA: tx = shift_q[0];
      ST_STOP: begin
        in_ready = bit_tick;
        done     = bit_tick;
      end
      default: tx = 1'b1;
    endcase
  end

endmodule

// File: rtl/count_uart_reporter.sv
// Watches count and reports each new value as "HH\n" over UART 8N1.
// One value is buffered; a newer capture overwrites it and is tallied in drops.
// Only the low 8 bits of the captured value are rendered as hex.
module count_uart_reporter
  import count_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] count,
  input  logic             report_en,
  output logic             tx,
  output logic             busy,
  output logic [CNT_W-1:0] reports_sent,
  output logic [CNT_W-1:0] drops
);

  localparam logic [1:0] LAST_BYTE = 2'(FRAME_BYTES - 1);

  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             busy_q, busy_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [7:0]       lo_char_q, lo_char_d;
  logic [CNT_W-1:0] reports_q, reports_d;
  logic [CNT_W-1:0] drops_q, drops_d;

  logic       capture;
  logic       launch;
  logic       byte_ready;
  logic       byte_done;
  logic       byte_valid;
  logic [7:0] byte_data;

  assign capture = report_en && (count != shadow_q);
  assign launch  = !busy_q && pending_q && byte_ready;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk      (clk),
    .reset    (reset),
    .in_valid (byte_valid),
    .in_data  (byte_data),
    .in_ready (byte_ready),
    .done     (byte_done),
    .tx       (tx)
  );

  // Capture, frame sequencing and statistics
  always_comb begin
    shadow_d   = shadow_q;
    pending_d  = pending_q;
    busy_d     = busy_q;
    byte_idx_d = byte_idx_q;
    lo_char_d  = lo_char_q;
    reports_d  = reports_q;
    drops_d    = drops_q;
    byte_valid = 1'b0;
    byte_data  = (byte_idx_q == 2'd0) ? lo_char_q : LF_CHAR;

    // Frame start uses the shadow value from before this edge's capture
    if (launch) begin
      byte_valid = 1'b1;
      byte_data  = hex_to_ascii(shadow_q[7:4]);
      lo_char_d  = hex_to_ascii(shadow_q[3:0]);
      byte_idx_d = 2'd0;
      busy_d     = 1'b1;
      pending_d  = 1'b0;
    end else if (busy_q && byte_done) begin
      if (byte_idx_q < LAST_BYTE) begin
        byte_valid = 1'b1;
        byte_idx_d = byte_idx_q + 2'd1;
      end else begin
        busy_d    = 1'b0;
        reports_d = reports_q + 1'b1;
      end
    end

    // A capture always leaves a value pending; overwriting an unsent one is a drop
    if (capture) begin
      shadow_d  = count;
      pending_d = 1'b1;
      if (pending_q && !launch && (drops_q != '1)) begin
        drops_d = drops_q + 1'b1;
      end
    end
  end

  // Register all top-level state
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q   <= '0;
      pending_q  <= 1'b0;
      busy_q     <= 1'b0;
      byte_idx_q <= '0;
      lo_char_q  <= '0;
      reports_q  <= '0;
      drops_q    <= '0;
    end else begin
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
      busy_q     <= busy_d;
      byte_idx_q <= byte_idx_d;
      lo_char_q  <= lo_char_d;
      reports_q  <= reports_d;
      drops_q    <= drops_d;
    end
  end

  assign busy         = busy_q;
  assign reports_sent = reports_q;
  assign drops        = drops_q;

endmodule

// File: tb/tb_count_uart_reporter.sv
// Scoreboard bench: a behavioural model predicts reported bytes and status,
// a UART receiver decodes tx and checks bytes against the expected queue.
module tb_count_uart_reporter;

  localparam int CPB       = 4;
  localparam int FRAME_CYC = 30 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       report_en = 1'b0;
  logic [7:0] count = 8'h00;
  logic       tx;
  logic       busy;
  logic [7:0] reports_sent;
  logic [7:0] drops;

  always #5 clk = ~clk;

  count_uart_reporter #(
    .CLKS_PER_BIT(CPB),
    .CNT_W       (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .count        (count),
    .report_en    (report_en),
    .tx           (tx),
    .busy         (busy),
    .reports_sent (reports_sent),
    .drops        (drops)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state
  logic [7:0] exp_q[$];
  logic [7:0] m_shadow = 8'h00;
  bit         m_pend = 1'b0;
  int         m_busy_left = 0;
  int         m_sent = 0;
  int         m_drops = 0;
  bit         m_consume;
  bit         m_capture;
  string      hexs = "0123456789ABCDEF";

  int         busy_cycles = 0;

  // Receiver state
  bit         rx_active = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = 8'h00;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: one update per clock edge from the inputs seen at that edge
  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_shadow = 8'h00;
      m_pend = 1'b0;
      m_busy_left = 0;
      m_sent = 0;
      m_drops = 0;
      exp_q.delete();
    end else begin
      m_consume = (m_busy_left == 0) && m_pend;
      m_capture = report_en && (count != m_shadow);
      if (m_busy_left > 0) begin
        m_busy_left--;
        if (m_busy_left == 0) m_sent++;
      end
      if (m_consume) begin
        exp_q.push_back(hexs[m_shadow[7:4]]);
        exp_q.push_back(hexs[m_shadow[3:0]]);
        exp_q.push_back(8'h0A);
        m_busy_left = FRAME_CYC;
      end
      if (m_capture) begin
        if (m_pend && !m_consume && (m_drops < 255)) m_drops++;
        m_shadow = count;
        m_pend = 1'b1;
      end else if (m_consume) begin
        m_pend = 1'b0;
      end
    end
  end

  // Per-cycle status monitor
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("busy", busy, (m_busy_left != 0));
      if (m_busy_left == 0) check("tx_idle", tx, 1);
      check("reports_sent", reports_sent, m_sent % 256);
      check("drops", drops, m_drops);
      if (busy) busy_cycles++;
    end
  end

  // UART receiver and scoreboard pop
  initial forever begin
    @(negedge clk);
    if (reset) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (tx == 1'b0) begin
        rx_active = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == CPB / 2) check("start_bit", tx, 0);
      if ((rx_cnt >= CPB + CPB / 2) && (rx_cnt < 9 * CPB) && (((rx_cnt - CPB / 2) % CPB) == 0))
        rx_byte[(rx_cnt - CPB - CPB / 2) / CPB] = tx;
      if (rx_cnt == 9 * CPB + CPB / 2) begin
        check("stop_bit", tx, 1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL rx_unexpected: got 0x%0h, expected no byte (t=%0t)", rx_byte, $time);
        end else begin
          check("rx_byte", rx_byte, exp_q.pop_front());
        end
        $display("rx byte 0x%02h t=%0t", rx_byte, $time);
        rx_active = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i;
    i = 0;
    while ((m_busy_left != 0 || m_pend || rx_active || exp_q.size() != 0) && i < budget) begin
      step(1);
      i++;
    end
    check({name, "_idle_in_time"}, int'(i < budget), 1);
    step(3);
  endtask

  task automatic wait_busy(input string name, input int budget);
    int i;
    i = 0;
    while (m_busy_left == 0 && i < budget) begin
      step(1);
      i++;
    end
    check({name, "_busy_in_time"}, int'(i < budget), 1);
  endtask

  initial begin
    // Single report of 0x3A
    count = 8'h00;
    report_en = 1'b1;
    do_reset();
    step(5);
    busy_cycles = 0;
    count = 8'h3A;
    step(1);
    wait_idle("p1", 400);
    check("p1_reports_sent", reports_sent, 1);
    check("p1_drops", drops, 0);
    check("p1_busy_cycles", busy_cycles, FRAME_CYC);
    $display("phase 1 report 0x3A done");

    // Unchanged count after reset: line stays idle
    do_reset();
    busy_cycles = 0;
    count = 8'h00;
    step(500);
    check("p2_busy_cycles", busy_cycles, 0);
    check("p2_reports_sent", reports_sent, 0);
    check("p2_drops", drops, 0);
    check("p2_tx", tx, 1);
    $display("phase 2 quiet hold done");

    // Overwrites during a report: latest wins
    do_reset();
    count = 8'h10;
    wait_busy("p3", 10);
    step(10);
    count = 8'h11; step(1);
    count = 8'h12; step(1);
    count = 8'h13; step(1);
    wait_idle("p3", 600);
    check("p3_reports_sent", reports_sent, 2);
    check("p3_drops", drops, 2);
    $display("phase 3 latest-wins done");

    // Reset in the middle of a frame
    do_reset();
    count = 8'h77;
    wait_busy("p4", 10);
    step(49);
    reset = 1'b1;
    count = 8'h00;
    step(1);
    reset = 1'b0;
    check("p4_tx_after_reset", tx, 1);
    check("p4_busy_after_reset", busy, 0);
    check("p4_reports_after_reset", reports_sent, 0);
    busy_cycles = 0;
    step(300);
    check("p4_busy_cycles", busy_cycles, 0);
    $display("phase 4 mid-frame reset done");

    // Disabled capture, then enable
    do_reset();
    report_en = 1'b0;
    count = 8'h55;
    busy_cycles = 0;
    step(50);
    check("p5_busy_while_disabled", busy_cycles, 0);
    report_en = 1'b1;
    step(1);
    check("p5_busy_at_capture", busy, 0);
    check("p5_tx_at_capture", tx, 1);
    step(1);
    check("p5_busy_rise", busy, 1);
    check("p5_tx_fall", tx, 0);
    wait_idle("p5", 400);
    check("p5_reports_sent", reports_sent, 1);
    $display("phase 5 enable edge done");

    // Continuous overwrites: drops saturates
    do_reset();
    report_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      count = count + 8'd1;
      step(1);
    end
    wait_idle("p6", 600);
    check("p6_drops_saturated", drops, 255);
    $display("phase 6 saturation done, reports=%0d", reports_sent);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 15) == 0) count = 8'($urandom);
      report_en = ($urandom_range(0, 9) != 0);
      step(1);
    end
    report_en = 1'b1;
    wait_idle("p7", 1000);
    check("p7_queue_empty", exp_q.size(), 0);
    $display("phase 7 random done, reports=%0d drops=%0d", reports_sent, drops);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
